imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate extender; generalises the fixed 16-to-32 sign extender.
- Takes a raw instruction word plus a format select and produces an XLEN-wide sign- or zero-extended immediate.
- Covers all RV32I/RV64I formats, the CSR zimm field, and the legacy 16-bit mode.
- Sits between instruction fetch/decode and the ALU operand mux for the pipelined core; two register stages with valid/ready backpressure.

---
 rtl/imm_ext_pkg.sv | 17 +
 rtl/imm_ext_pipe_decode.sv | 35 +++
 rtl/imm_ext_pipe.sv | 99 +++++++++
 tb/tb_imm_ext_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the pipelined immediate extender: format encodings and XLEN legality.
package imm_ext_pkg;

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_Z   = 3'd5;
  localparam logic [2:0] FMT_H16 = 3'd6;
  localparam logic [2:0] FMT_RSV = 3'd7;

  function automatic bit xlen_legal(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_ext_pipe_decode.sv
// Combinational immediate decoder: builds a 32-bit immediate per format, then widens to XLEN.
module imm_decode
  import imm_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      fmt_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic        s;
  logic [31:0] imm32;

  assign s = instr_i[31];

  always_comb begin
    imm32     = '0;
    illegal_o = 1'b0;
    case (fmt_i)
      FMT_I:   imm32 = {{20{s}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, instr_i[19:15]};
      FMT_H16: imm32 = {{16{instr_i[15]}}, instr_i[15:0]};
      default: illegal_o = 1'b1;
    endcase
    // Every 32-bit form is already correctly signed, so widening is a plain sign extension.
    imm_o = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate extender with valid/ready backpressure, flush and an illegal-result counter.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_cnt
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_instr_q;
  logic [2:0]       s1_fmt_q;
  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  s2_imm_q;
  logic             s2_illegal_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic             s2_load, accept, out_hs;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (s1_instr_q),
    .fmt_i     (s1_fmt_q),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    accept   = in_valid && in_ready;
    out_hs   = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    if (flush)        s1_valid_d = 1'b0;
    else if (accept)  s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (flush)        s2_valid_d = 1'b0;
    else if (s2_load) s2_valid_d = 1'b1;
    else if (out_hs)  s2_valid_d = 1'b0;

    // Flush does not cancel the handshake in progress, so it still counts.
    err_cnt_d = err_cnt_q;
    if (out_hs && s2_illegal_q && (err_cnt_q != CntMax)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_instr_q   <= '0;
      s1_fmt_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_imm_q     <= '0;
      s2_illegal_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      err_cnt_q  <= err_cnt_d;
      if (accept) begin
        s1_instr_q <= in_instr;
        s1_fmt_q   <= in_fmt;
      end
      if (s2_load) begin
        s2_imm_q     <= dec_imm;
        s2_illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_imm     = s2_imm_q;
  assign out_illegal = s2_illegal_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share stimulus; an arithmetic model predicts results.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_fmt = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [7:0]  err_cnt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [7:0]  err_cnt64;

  int n_checks = 0;
  int n_pass   = 0;

  logic [64:0] exp_q[$];
  int          model_err = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev32;
  logic [63:0] prev64;
  logic        prev_ill;

  imm_ext_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_illegal(out_illegal32), .err_cnt(err_cnt32)
  );

  imm_ext_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_illegal(out_illegal64), .err_cnt(err_cnt64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference: immediate value as a signed integer built from the instruction fields.
  function automatic logic [64:0] model(input logic [31:0] i, input logic [2:0] f);
    longint v;
    logic   ill;
    ill = 1'b0;
    case (f)
      3'd0: begin v = longint'(i[31:20]); if (v >= 2048) v -= 4096; end
      3'd1: begin v = longint'({i[31:25], i[11:7]}); if (v >= 2048) v -= 4096; end
      3'd2: v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
                - (i[31] ? 64'sd4096 : 64'sd0);
      3'd3: v = longint'(i[31:12]) * 4096 - (i[31] ? 64'sh1_0000_0000 : 64'sd0);
      3'd4: v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
                - (i[31] ? 64'sd1048576 : 64'sd0);
      3'd5: v = longint'(i[19:15]);
      3'd6: begin v = longint'(i[15:0]); if (i[15]) v -= 65536; end
      default: begin v = 0; ill = 1'b1; end
    endcase
    return {ill, 64'(v)};
  endfunction

  // Monitor: samples mid-cycle what the coming rising edge will act on.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      exp_q.delete();
      model_err  = 0;
      stall_prev = 1'b0;
    end else begin
      check("err_cnt32", 64'(err_cnt32), 64'(model_err));
      check("err_cnt64", 64'(err_cnt64), 64'(model_err));
      if (stall_prev && out_valid32) begin
        check("stall_imm32", 64'(out_imm32), 64'(prev32));
        check("stall_imm64", out_imm64, prev64);
        check("stall_ill", 64'(out_illegal32), 64'(prev_ill));
      end
      if (out_valid32) check("valid_has_item", 64'(exp_q.size() != 0), 64'd1);
      if (out_valid32 && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imm32", 64'(out_imm32), 64'(e[31:0]));
        check("imm64", out_imm64, e[63:0]);
        check("illegal32", 64'(out_illegal32), 64'(e[64]));
        check("illegal64", 64'(out_illegal64), 64'(e[64]));
        if (e[64] && model_err < 255) model_err++;
      end
      stall_prev = out_valid32 && !out_ready && !flush;
      prev32     = out_imm32;
      prev64     = out_imm64;
      prev_ill   = out_illegal32;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready32) exp_q.push_back(model(in_instr, in_fmt));
    end
  end

  task automatic issue(input logic [31:0] instr, input logic [2:0] fmt);
    in_valid = 1'b1;
    in_instr = instr;
    in_fmt   = fmt;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready32) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] v_instr[8] = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h800000B7,
                              32'h000FF073, 32'h00008001, 32'h00007FFF, 32'h12345678};
  logic [2:0]  v_fmt[8]   = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd6, 3'd7};
  logic [63:0] v_exp64[8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                              64'hFFFFFFFF80000000, 64'h1F, 64'hFFFFFFFFFFFF8001,
                              64'h7FFF, 64'h0};
  logic [31:0] v_exp32[8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h80000000, 32'h1F,
                              32'hFFFF8001, 32'h7FFF, 32'h0};

  initial begin
    #2;
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_out_imm", out_imm64, 64'd0);
    check("rst_illegal", 64'(out_illegal32), 64'd0);
    check("rst_err_cnt", 64'(err_cnt32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Directed vectors one at a time: latency and fixed expected values.
    for (int v = 0; v < 8; v++) begin
      issue(v_instr[v], v_fmt[v]);
      in_valid = 1'b0;
      check("latency_not_yet", 64'(out_valid32), 64'd0);
      tick(1);
      check("latency_valid", 64'(out_valid32), 64'd1);
      check("dir_imm32", 64'(out_imm32), 64'(v_exp32[v]));
      check("dir_imm64", out_imm64, v_exp64[v]);
      check("dir_illegal", 64'(out_illegal64), 64'(v_fmt[v] == 3'd7));
      tick(1);
    end

    // Back-to-back burst.
    for (int k = 0; k < 10; k++) issue($urandom, 3'($urandom_range(0, 6)));
    in_valid = 1'b0;
    tick(4);
    check("burst_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: two accepted, third blocked while stalled.
    out_ready = 1'b0;
    issue(32'hFFF00093, 3'd0);
    issue(32'h00008001, 3'd6);
    in_instr = 32'h0080006F;
    in_fmt   = 3'd4;
    check("bp_in_ready_low", 64'(in_ready32), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("bp_hold_ready", 64'(in_ready32), 64'd0);
      check("bp_hold_valid", 64'(out_valid32), 64'd1);
    end
    out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Saturation of the illegal counter.
    for (int k = 0; k < 300; k++) issue($urandom, 3'd7);
    in_valid = 1'b0;
    tick(4);
    check("sat_err32", 64'(err_cnt32), 64'd255);
    check("sat_err64", 64'(err_cnt64), 64'd255);

    // Flush with two items in flight.
    out_ready = 1'b0;
    issue(32'h11111111, 3'd0);
    issue(32'h22222222, 3'd1);
    in_valid = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid32), 64'd0);
    check("flush_in_ready", 64'(in_ready32), 64'd1);
    out_ready = 1'b1;
    tick(5);
    check("flush_no_ghost", 64'(out_valid32), 64'd0);
    check("flush_keeps_err", 64'(err_cnt32), 64'd255);

    // Asynchronous reset mid-stream.
    issue(32'h0000FFFF, 3'd7);
    issue(32'hABCDE000, 3'd3);
    in_instr = 32'h0;
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid64), 64'd0);
    check("arst_out_imm", out_imm64, 64'd0);
    check("arst_illegal", 64'(out_illegal32), 64'd0);
    check("arst_err_cnt", 64'(err_cnt32), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomised traffic with occasional flush.
    for (int k = 0; k < 2000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_fmt    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick(1);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick(6);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(out_valid32), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
